// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, ALU op codes and FSM states.
package alu_pkg;

  localparam logic [7:0] OpcEcho = 8'hEC;
  localparam logic [7:0] OpcAdd  = 8'hA1;
  localparam logic [7:0] OpcMul  = 8'hA2;
  localparam logic [7:0] OpcDiv  = 8'hA3;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluMul = 2'd1,
    AluDiv = 2'd2
  } alu_op_e;

  typedef enum logic [4:0] {
    StIdle    = 5'd0,
    StRsv     = 5'd1,
    StLenLo   = 5'd2,
    StLenHi   = 5'd3,
    StEcho    = 5'd4,
    StOpnd    = 5'd5,
    StAluReq  = 5'd6,
    StAluWait = 5'd7,
    StTxRes   = 5'd8,
    StDrain   = 5'd9
  } state_e;

  function automatic logic is_arith(input logic [7:0] opc);
    return (opc == OpcAdd) || (opc == OpcMul) || (opc == OpcDiv);
  endfunction

  function automatic alu_op_e op_of(input logic [7:0] opc);
    unique case (opc)
      OpcMul:  return AluMul;
      OpcDiv:  return AluDiv;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_seq.sv
// Packet-driven command sequencer: echoes payloads or chains operands through an external ALU
// and returns the 32-bit accumulator as four bytes.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int unsigned timeout_p = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_start_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_result_i,
  output logic [4:0]  state_o,
  output logic        err_o
);

  localparam int unsigned TimerW = $clog2(timeout_p + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(timeout_p - 1);

  state_e              state_q, state_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         opnd_q, opnd_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [1:0]          tx_idx_q, tx_idx_d;
  logic                first_q, first_d;
  logic                err_q, err_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  alu_op_e             alu_op_q, alu_op_d;

  logic [15:0] len;
  logic [15:0] payload;
  logic [31:0] opnd_full;

  assign len       = {data_i, len_lo_q};
  assign payload   = (len < 16'd4) ? 16'd0 : len - 16'd4;
  assign opnd_full = {data_i, opnd_q[23:0]};

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    len_lo_d    = len_lo_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    byte_idx_d  = byte_idx_q;
    tx_idx_d    = tx_idx_q;
    first_d     = first_q;
    err_d       = err_q;
    timer_d     = timer_q;
    alu_op_d    = alu_op_q;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    data_o      = 8'h00;
    alu_start_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        if (valid_i) begin
          opcode_d = data_i;
          state_d  = StRsv;
        end
      end
      StRsv: begin
        ready_o = 1'b1;
        if (valid_i) state_d = StLenLo;
      end
      StLenLo: begin
        ready_o = 1'b1;
        if (valid_i) begin
          len_lo_d = data_i;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        ready_o = 1'b1;
        if (valid_i) begin
          cnt_d      = payload;
          acc_d      = 32'd0;
          byte_idx_d = 2'd0;
          tx_idx_d   = 2'd0;
          first_d    = 1'b1;
          if (is_arith(opcode_q)) alu_op_d = op_of(opcode_q);
          if (!is_arith(opcode_q) && opcode_q != OpcEcho) err_d = 1'b1;
          if (payload == 16'd0) begin
            state_d = is_arith(opcode_q) ? StTxRes : StIdle;
          end else if (opcode_q == OpcEcho) begin
            state_d = StEcho;
          end else if (is_arith(opcode_q)) begin
            state_d = StOpnd;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StEcho: begin
        ready_o = ready_i;
        valid_o = valid_i;
        data_o  = data_i;
        if (valid_i && ready_i) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) state_d = StIdle;
        end
      end
      StOpnd: begin
        ready_o = 1'b1;
        if (valid_i) begin
          cnt_d                            = cnt_q - 16'd1;
          byte_idx_d                       = byte_idx_q + 2'd1;
          opnd_d[{byte_idx_q, 3'b000} +: 8] = data_i;
          if (byte_idx_q == 2'd3) begin
            if (first_q) begin
              acc_d   = opnd_full;
              first_d = 1'b0;
              if (cnt_q <= 16'd1) state_d = StTxRes;
            end else begin
              state_d = StAluReq;
            end
          end else if (cnt_q <= 16'd1) begin
            // Trailing partial operand is dropped.
            state_d = StTxRes;
          end
        end
      end
      StAluReq: begin
        alu_start_o = 1'b1;
        timer_d     = '0;
        state_d     = StAluWait;
      end
      StAluWait: begin
        if (alu_done_i) begin
          acc_d   = alu_result_i;
          state_d = (cnt_q == 16'd0) ? StTxRes : StOpnd;
        end else if (timer_q == TimerMax) begin
          err_d   = 1'b1;
          state_d = (cnt_q == 16'd0) ? StIdle : StDrain;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StTxRes: begin
        valid_o = 1'b1;
        data_o  = acc_q[{tx_idx_q, 3'b000} +: 8];
        if (ready_i) begin
          tx_idx_d = tx_idx_q + 2'd1;
          if (tx_idx_q == 2'd3) state_d = StIdle;
        end
      end
      StDrain: begin
        ready_o = 1'b1;
        if (valid_i) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      opcode_q   <= 8'h00;
      len_lo_q   <= 8'h00;
      cnt_q      <= 16'd0;
      acc_q      <= 32'd0;
      opnd_q     <= 32'd0;
      byte_idx_q <= 2'd0;
      tx_idx_q   <= 2'd0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      alu_op_q   <= AluAdd;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_lo_q   <= len_lo_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      byte_idx_q <= byte_idx_d;
      tx_idx_q   <= tx_idx_d;
      first_q    <= first_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      alu_op_q   <= alu_op_d;
    end
  end

  assign alu_op_o = alu_op_q;
  assign alu_a_o  = acc_q;
  assign alu_b_o  = opnd_q;
  assign state_o  = state_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq: echo, arithmetic chains, backpressure, unknown opcode,
// reset mid-packet and ALU timeout.
module tb_alu_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_start_o;
  logic        alu_done_i;
  logic [31:0] alu_result_i;
  logic [4:0]  state_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  logic [7:0]  txq[$];
  logic [31:0] sa[$];
  logic [31:0] sb[$];
  logic [1:0]  sop[$];
  logic        alu_en = 1'b1;
  logic        bp_en = 1'b0;
  int          dly = 0;
  logic [31:0] res = 32'd0;

  alu_cmd_seq #(.timeout_p(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .alu_op_o    (alu_op_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_start_o (alu_start_o),
    .alu_done_i  (alu_done_i),
    .alu_result_i(alu_result_i),
    .state_o     (state_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid_o && ready_i) txq.push_back(data_o);
  end

  // ALU stand-in: answers two cycles after each start unless disabled.
  always @(posedge clk) begin
    alu_done_i <= 1'b0;
    if (alu_start_o) begin
      sa.push_back(alu_a_o);
      sb.push_back(alu_b_o);
      sop.push_back(alu_op_o);
      if (alu_en) begin
        dly <= 2;
        case (alu_op_o)
          2'd0:    res <= alu_a_o + alu_b_o;
          2'd1:    res <= alu_a_o * alu_b_o;
          default: res <= (alu_b_o != 0) ? alu_a_o / alu_b_o : 32'd0;
        endcase
      end
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        alu_done_i   <= 1'b1;
        alu_result_i <= res;
      end
    end
  end

  always @(negedge clk) begin
    if (bp_en) ready_i = ~ready_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    #1;
    while (!ready_o && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ready_o) check("send_timeout", 32'(ready_o), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  task automatic clear_q();
    txq.delete();
    sa.delete();
    sb.delete();
    sop.delete();
  endtask

  task automatic wait_tx(input string tag, input int n);
    int k = 0;
    while (txq.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    check(tag, 32'(txq.size()), 32'(n));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    rst     = 1'b1;
    data_i  = 8'h00;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_start", 32'(alu_start_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_op", 32'(alu_op_o), 32'd0);
    check("rst_a", alu_a_o, 32'd0);
    check("rst_b", alu_b_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready_o), 32'd1);

    // Echo
    clear_q();
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h07); send_byte(8'h00);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    idle();
    wait_tx("echo_cnt", 3);
    if (txq.size() == 3) begin
      check("echo_b0", 32'(txq[0]), 32'h41);
      check("echo_b1", 32'(txq[1]), 32'h42);
      check("echo_b2", 32'(txq[2]), 32'h43);
    end
    check("echo_err", 32'(err_o), 32'd0);
    check("echo_state", 32'(state_o), 32'd0);

    // Length below header size saturates to empty payload
    clear_q();
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    idle();
    wait_tx("short_cnt", 0);
    check("short_state", 32'(state_o), 32'd0);

    // Add chain 1+2+3
    clear_q();
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_word(32'd1); send_word(32'd2); send_word(32'd3);
    idle();
    wait_tx("add_cnt", 4);
    check("add_starts", 32'(sa.size()), 32'd2);
    if (sa.size() == 2) begin
      check("add_a0", sa[0], 32'd1);
      check("add_b0", sb[0], 32'd2);
      check("add_a1", sa[1], 32'd3);
      check("add_b1", sb[1], 32'd3);
      check("add_op", 32'(sop[0]), 32'd0);
    end
    if (txq.size() == 4) begin
      check("add_tx", {txq[3], txq[2], txq[1], txq[0]}, 32'h0000_0006);
    end

    // Mul with TX backpressure
    clear_q();
    bp_en = 1'b1;
    send_byte(8'hA2); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_word(32'h0102_0304); send_word(32'd2);
    idle();
    wait_tx("mul_cnt", 4);
    bp_en = 1'b0;
    ready_i = 1'b1;
    if (txq.size() == 4) begin
      check("mul_tx", {txq[3], txq[2], txq[1], txq[0]}, 32'h0204_0608);
    end
    if (sop.size() == 1) check("mul_op", 32'(sop[0]), 32'd1);

    // Div 100/7
    clear_q();
    send_byte(8'hA3); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_word(32'd100); send_word(32'd7);
    idle();
    wait_tx("div_cnt", 4);
    if (txq.size() == 4) check("div_tx", {txq[3], txq[2], txq[1], txq[0]}, 32'd14);
    if (sop.size() == 1) check("div_op", 32'(sop[0]), 32'd2);

    // Trailing partial operand dropped
    clear_q();
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h0A); send_byte(8'h00);
    send_word(32'd5); send_byte(8'h09); send_byte(8'h09);
    idle();
    wait_tx("part_cnt", 4);
    if (txq.size() == 4) check("part_tx", {txq[3], txq[2], txq[1], txq[0]}, 32'd5);
    check("part_starts", 32'(sa.size()), 32'd0);

    // Arithmetic with empty payload returns zero
    clear_q();
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
    idle();
    wait_tx("zero_cnt", 4);
    if (txq.size() == 4) check("zero_tx", {txq[3], txq[2], txq[1], txq[0]}, 32'd0);

    // Unknown opcode drained, then echo
    clear_q();
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h06); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h7E);
    idle();
    wait_tx("unk_cnt", 1);
    if (txq.size() == 1) check("unk_tx", 32'(txq[0]), 32'h7E);
    check("unk_err", 32'(err_o), 32'd1);

    // Reset in the middle of an operand
    clear_q();
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h01);
    @(negedge clk);
    data_i  = 8'h02;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b0;
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h11);
    idle();
    wait_tx("rst_echo_cnt", 1);
    if (txq.size() == 1) check("rst_echo_tx", 32'(txq[0]), 32'h11);

    // ALU timeout
    clear_q();
    alu_en = 1'b0;
    send_byte(8'hA2); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_word(32'd3); send_word(32'd4);
    idle();
    repeat (4000) @(negedge clk);
    check("to_early_err", 32'(err_o), 32'd0);
    check("to_wait_state", 32'(state_o), 32'd7);
    begin
      int k = 0;
      while (!err_o && k < 300) begin
        @(negedge clk);
        k++;
      end
    end
    check("to_err", 32'(err_o), 32'd1);
    repeat (4) @(negedge clk);
    check("to_state", 32'(state_o), 32'd0);
    check("to_tx", 32'(txq.size()), 32'd0);
    check("to_starts", 32'(sa.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter timeout_p, default 4096: max cycles spent in ALU_WAIT before abort.
REQ-002 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port data_i / valid_i / ready_o, in/in/out, 8/1/1: byte stream from RX pipeline; transfer when valid_i && ready_o.
REQ-005 Port data_o / valid_o / ready_i, out/out/in, 8/1/1: byte stream to TX pipeline; transfer when valid_o && ready_i.
REQ-006 Port alu_op_o, output, 2: 0=add, 1=mul, 2=div; held stable while alu_start_o or ALU_WAIT.
REQ-007 Port alu_a_o / alu_b_o, output, 32 each: accumulator / current operand.
REQ-008 Port alu_start_o, output, 1: single-cycle pulse launching ALU op.
REQ-009 Port alu_done_i / alu_result_i, input, 1/32: ALU completion pulse and result, sampled same cycle.
REQ-010 Port state_o, output, 5: one-hot-free encoded current state, for LEDs.
REQ-011 Port err_o, output, 1: sticky flag, set on unknown opcode or ALU timeout; cleared only by rst.

Function
REQ-012 Packet: byte0 opcode, byte1 reserved (ignored), byte2 len[7:0], byte3 len[15:8]; len = total bytes incl. header.
REQ-013 Opcodes: 0xEC echo, 0xA1 add, 0xA2 mul, 0xA3 div; any other is unknown.
REQ-014 States: IDLE, RSV, LEN_LO, LEN_HI, ECHO, OPND, ALU_REQ, ALU_WAIT, TX_RES, DRAIN.
REQ-015 IDLE/RSV/LEN_LO/LEN_HI: ready_o=1, advance one state per accepted byte; LEN_HI computes payload = len-4, saturating at 0.
REQ-016 From LEN_HI: payload=0 -> IDLE for echo/unknown, TX_RES with acc=0 for arithmetic; else echo->ECHO, arith->OPND, unknown->DRAIN with err_o set.
REQ-017 ECHO: ready_o = ready_i, valid_o = valid_i, data_o = data_i (combinational pass-through); decrement count per transfer; last byte -> IDLE.
REQ-018 OPND: ready_o=1; assemble 4 bytes little-endian into operand; first operand loads acc directly; each later operand -> ALU_REQ.
REQ-019 ALU_REQ: alu_start_o=1 for exactly one cycle, then ALU_WAIT; ready_o=0 in ALU_REQ and ALU_WAIT.
REQ-020 ALU_WAIT: on alu_done_i, acc <= alu_result_i; return to OPND if payload bytes remain, else TX_RES.
REQ-021 ALU_WAIT timeout: timeout_p cycles without alu_done_i -> set err_o, DRAIN remaining payload, no result sent.
REQ-022 Payload length not multiple of 4: trailing 1-3 bytes accepted and discarded; then TX_RES.
REQ-023 TX_RES: send acc as 4 bytes, LSB first; valid_o held with data stable until ready_i; after 4th transfer -> IDLE.
REQ-024 DRAIN: ready_o=1, discard bytes until payload count reaches 0, then IDLE; valid_o=0.
REQ-025 Outside ECHO and TX_RES, valid_o=0; outside header/ECHO/OPND/DRAIN, ready_o=0.
REQ-026 Arithmetic is 32-bit wrap-around; block performs no arithmetic itself besides counters.
REQ-027 alu_done_i outside ALU_WAIT is ignored.

Reset
REQ-028 On rst: state IDLE, acc=0, counters=0, err_o=0, valid_o=0, alu_start_o=0, data_o=0, alu_op_o=0, alu_a_o=0, alu_b_o=0.
REQ-029 rst mid-packet or mid-ALU op abandons it; first byte after rst is treated as opcode.

Structure
REQ-030 Shared package alu_pkg holds opcode constants, alu_op enum, and state enum.
REQ-031 No sub-module required; byte counter and timeout counter are in-line.

Verification
REQ-032 Echo: EC 00 07 00 41 42 43 -> TX 41 42 43; err_o=0.
REQ-033 Add: A1 00 10 00, operands 1,2,3 (LE) -> two start pulses with (1,2),(3,3); model returns sum; TX 06 00 00 00.
REQ-034 Backpressure: ready_i toggled every other cycle during TX_RES -> bytes unchanged, no drop or duplicate.
REQ-035 Unknown: 55 00 06 00 AA BB then EC 00 05 00 7E -> err_o=1, only 7E transmitted.
REQ-036 Timeout: A2 00 0C 00 with 2 operands, alu_done_i never asserted -> err_o after timeout_p cycles, nothing sent, return to IDLE.
REQ-037 Reset mid-operand: rst during OPND byte 2 -> next EC 00 05 00 11 yields TX 11.
